// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port.
// One op in flight; req/ready + rvalid handshake, lane strobes, load extension, flush/drain.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        exc_valid,
  output logic [3:0]  exc_cause
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StResp,
    StExc,
    StDrain
  } state_e;

  // Only meaningful when TIMEOUT != 0.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] ext_c;

  assign in_ready = (state_q == StIdle);

  always_comb begin
    accept = in_valid && (state_q == StIdle) && (in_load || in_store) && !flush;

    if (in_load) begin
      illegal = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) || (in_funct3 == 3'd7);
    end else begin
      illegal = in_funct3[2] || (in_funct3[1:0] == 2'd3);
    end

    case (in_funct3[1:0])
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = 1'b0;
    endcase

    case (in_funct3[1:0])
      2'd0: begin
        strb_c  = 4'b0001 << in_addr[1:0];
        wdata_c = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        strb_c  = 4'b0011 << in_addr[1:0];
        wdata_c = {2{in_wdata[15:0]}};
      end
      default: begin
        strb_c  = 4'hF;
        wdata_c = in_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    ext_c = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ext_c = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    ext_c = {24'b0, shifted[7:0]};
      3'd5:    ext_c = {16'b0, shifted[15:0]};
      default: ext_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      is_load_q <= 1'b0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      done      <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 4'd0;
    end else begin
      done      <= 1'b0;
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_load_q <= in_load;
            funct3_q  <= in_funct3;
            off_q     <= in_addr[1:0];
            rd_q      <= in_rd;
            mem_we    <= in_store;
            mem_addr  <= {in_addr[31:2], 2'b00};
            mem_wdata <= wdata_c;
            mem_wstrb <= in_store ? strb_c : 4'd0;
            if (illegal) begin
              state_q   <= StExc;
              exc_valid <= 1'b1;
              exc_cause <= 4'd2;
            end else if (misaligned) begin
              state_q   <= StExc;
              exc_valid <= 1'b1;
              exc_cause <= in_load ? 4'd4 : 4'd6;
            end else begin
              state_q <= StReq;
              mem_req <= 1'b1;
            end
          end
        end
        StReq: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            cnt_q   <= '0;
            if (!is_load_q) begin
              // A store taken by memory is committed even if flushed.
              if (flush) begin
                state_q <= StIdle;
              end else begin
                state_q <= StResp;
                done    <= 1'b1;
              end
            end else begin
              state_q <= flush ? StDrain : StWait;
            end
          end else if (flush) begin
            mem_req <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= mem_rvalid ? StIdle : StDrain;
          end else if (mem_rvalid) begin
            state_q  <= StResp;
            wb_valid <= 1'b1;
            done     <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ext_c;
          end else if ((TIMEOUT != 0) && (cnt_q == LastCnt)) begin
            state_q   <= StExc;
            exc_valid <= 1'b1;
            exc_cause <= 4'd5;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (mem_rvalid) begin
            state_q <= StIdle;
          end
        end
        StResp:  state_q <= StIdle;
        StExc:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: the driver schedules each op and memory response and
// publishes the expected outputs per cycle; one process compares them on the falling edge.
module tb_lsu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store, flush;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  exc_cause;

  lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic        e_ready, e_req, e_we, e_wbv, e_done, e_excv;
  logic [31:0] e_addr, e_wdata, e_wbdata;
  logic [3:0]  e_strb, e_cause;
  logic [4:0]  e_wbrd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("done", 32'(done), 32'(e_done));
      chk("exc_valid", 32'(exc_valid), 32'(e_excv));
      chk("wb_data", wb_data, e_wbdata);
      chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
      chk("exc_cause", 32'(exc_cause), 32'(e_cause));
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // ---- reference rules ----
  function automatic bit ref_legal(input bit ld, input logic [2:0] f3);
    logic [7:0] m;
    m = ld ? 8'b0011_0111 : 8'b0000_0111;
    return m[f3];
  endfunction

  function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned base;
    base = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 3 : 15;
    return 4'(base << a[1:0]);
  endfunction

  function automatic logic [31:0] ref_lane(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'd0) return (w % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] s, b, h;
    s = d >> (8 * a[1:0]);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // ---- driver ----
  task automatic step();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_load    = 1'b0;
    in_store   = 1'b0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    in_funct3  = 3'($urandom);
    in_addr    = $urandom;
    in_wdata   = $urandom;
    in_rd      = 5'($urandom);
    mem_rdata  = $urandom;
    e_ready = 1'b0;
    e_req   = 1'b0;
    e_wbv   = 1'b0;
    e_done  = 1'b0;
    e_excv  = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      e_ready = 1'b1;
      case ($urandom_range(0, 3))
        0: in_valid = 1'b1;
        1: begin in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'd2; flush = 1'b1; end
        2: mem_rvalid = 1'b1;
        default: ;
      endcase
      step();
    end
    e_ready = 1'b1;
  endtask

  // fl_req / fl_wait / rv_dly are cycle indices within REQ and WAIT/DRAIN; -1 means never.
  task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly, input int fl_req, input int fl_wait);
    bit drain;
    e_ready   = 1'b1;
    in_valid  = 1'b1;
    in_load   = ld;
    in_store  = !ld;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wd;
    in_rd     = rd;
    step();
    if (!ref_legal(ld, f3) || ref_misal(f3, addr)) begin
      e_excv  = 1'b1;
      e_cause = !ref_legal(ld, f3) ? 4'd2 : (ld ? 4'd4 : 4'd6);
      step();
      e_ready = 1'b1;
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      e_req     = 1'b1;
      e_we      = !ld;
      e_addr    = {addr[31:2], 2'b00};
      e_strb    = ld ? 4'h0 : ref_strb(f3, addr);
      e_wdata   = ref_lane(f3, wd);
      mem_ready = (k == rdy_dly);
      flush     = (k == fl_req);
      if (k == fl_req && k != rdy_dly) begin
        step();
        e_ready = 1'b1;
        return;
      end
      step();
    end
    drain = (fl_req == rdy_dly);
    if (!ld) begin
      if (!drain) begin
        e_done = 1'b1;
        step();
      end
      e_ready = 1'b1;
      return;
    end
    for (int w = 0; w < 64; w++) begin
      if (w == rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        if (!drain && w == fl_wait) flush = 1'b1;
        if (drain || w == fl_wait) begin
          step();
          e_ready = 1'b1;
          return;
        end
        step();
        e_wbv    = 1'b1;
        e_done   = 1'b1;
        e_wbrd   = rd;
        e_wbdata = ref_load(f3, addr, rdata);
        step();
        e_ready = 1'b1;
        return;
      end
      if (!drain && w == fl_wait) begin
        flush = 1'b1;
        drain = 1'b1;
        step();
        continue;
      end
      if (!drain && w == int'(TO) - 1) begin
        step();
        e_excv  = 1'b1;
        e_cause = 4'd5;
        step();
        e_ready = 1'b1;
        return;
      end
      step();
    end
  endtask

  function automatic logic [2:0] pick_load_f3(input int i);
    case (i)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          rdy, rv, flr, flw;

    rst = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; flush = 1'b0;
    in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_done = 1'b0; e_excv = 1'b0;
    e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_strb = 4'd0;
    e_wbdata = 32'd0; e_wbrd = 5'd0; e_cause = 4'd0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    e_ready = 1'b1;
    idle_gap(2);

    run_op(1, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 32'h80FF_1234, 0, 0, -1, -1);
    chk("lit_lb", wb_data, 32'hFFFF_FF80);
    chk("lit_lb_rd", 32'(wb_rd), 32'd7);
    run_op(1, 3'd5, 32'h0000_0102, 32'd0, 5'd3, 32'h8001_0000, 0, 1, -1, -1);
    chk("lit_lhu", wb_data, 32'h0000_8001);
    run_op(1, 3'd1, 32'h0000_0102, 32'd0, 5'd4, 32'h8001_0000, 1, 0, -1, -1);
    chk("lit_lh", wb_data, 32'hFFFF_8001);
    run_op(0, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 32'd0, 3, 0, -1, -1);
    chk("lit_sh_wb_held", wb_data, 32'hFFFF_8001);
    run_op(1, 3'd2, 32'h0000_0101, 32'd0, 5'd1, 32'd0, 0, 0, -1, -1);
    chk("lit_misal", 32'(exc_cause), 32'd4);
    run_op(1, 3'd3, 32'h0000_0101, 32'd0, 5'd1, 32'd0, 0, 0, -1, -1);
    chk("lit_illegal", 32'(exc_cause), 32'd2);
    run_op(1, 3'd2, 32'h0000_0500, 32'd0, 5'd2, 32'd0, 0, -1, -1, -1);
    chk("lit_timeout", 32'(exc_cause), 32'd5);
    run_op(1, 3'd2, 32'h0000_0600, 32'd0, 5'd9, 32'hDEAD_BEEF, 0, 2, -1, 0);
    run_op(1, 3'd2, 32'h0000_0300, 32'd0, 5'd11, 32'h1234_5678, 0, 0, -1, -1);
    chk("lit_lw", wb_data, 32'h1234_5678);
    chk("lit_lw_rd", 32'(wb_rd), 32'd11);
    idle_gap(1);

    // Async reset while a load waits for rvalid; the late response must be ignored.
    e_ready = 1'b1;
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'd2; in_addr = 32'h0000_0400; in_rd = 5'd5;
    step();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0400; e_strb = 4'd0; mem_ready = 1'b1;
    step();
    rst = 1'b1;
    e_ready = 1'b1; e_wbdata = 32'd0; e_wbrd = 5'd0; e_cause = 4'd0;
    #1 chk("rst_req_drop", 32'(mem_req), 32'd0);
    step();
    rst = 1'b0;
    e_ready = 1'b1;
    mem_rvalid = 1'b1;
    step();
    idle_gap(2);

    for (int n = 0; n < 300; n++) begin
      ld = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else f3 = ld ? pick_load_f3($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rdy = $urandom_range(0, 3);
      rv  = $urandom_range(0, 6);
      flr = -1;
      flw = -1;
      case ($urandom_range(0, 5))
        0: flr = $urandom_range(0, rdy);
        1: flw = $urandom_range(0, 3);
        default: ;
      endcase
      run_op(ld, f3, addr, $urandom, 5'($urandom), $urandom, rdy, rv, flr, flw);
      idle_gap($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory port of the RV32 core.
- Accepts one memory op at a time and detects misalignment and illegal funct3.
- Drives a req/ready + rvalid memory handshake with byte-lane strobes, and extracts and sign/zero-extends load data.
- Returns a single-cycle writeback or exception pulse; a flush input aborts or drains an op already in flight.

Parameters:
TIMEOUT, 255, cycles allowed in WAIT before access fault; 0 disables timeout.
CNT_W, 8, width of timeout counter; TIMEOUT must be < 2**CNT_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  op offered by execute
in_ready  out  1  controller can accept (state==IDLE)
in_load  in  1  op is load (in_load and in_store never both 1)
in_store  in  1  op is store
in_funct3  in  3  RV32 funct3
in_addr  in  32  effective byte address
in_wdata  in  32  store data (rs2)
in_rd  in  5  load destination register
flush  in  1  abort current op
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables (0 for loads)
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
wb_valid  out  1  load result pulse
wb_rd  out  5  load destination
wb_data  out  32  extended load data
done  out  1  op retired pulse (load or store, success only)
exc_valid  out  1  exception pulse
exc_cause  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault

Behaviour:
- Reset: state=IDLE. All outputs 0 except in_ready=1. Counter=0.
- Accept: in_valid & in_ready & (in_load|in_store) & ~flush. Latch op, funct3, addr, wdata, rd. Valid with neither in_load nor in_store is ignored.
- Checks at accept, combinational on inputs:
  - Illegal funct3: load ∉{0,1,2,4,5}, store ∉{0,1,2}.
  - Misaligned: halfword addr[0]≠0, word addr[1:0]≠0.
  - On either, go to EXC with no memory traffic. Illegal has priority over misaligned.
- States: IDLE, REQ, WAIT, RESP, EXC, DRAIN.
- IDLE: good accept → REQ next cycle.
- REQ: mem_req=1, outputs held stable until mem_ready.
  - mem_ready & store → RESP.
  - mem_ready & load → WAIT, counter cleared.
  - flush & ~mem_ready → IDLE with no request issued.
  - flush & mem_ready (same cycle) → load: DRAIN; store: IDLE. A store accepted by memory is committed.
- WAIT:
  - mem_rvalid → RESP; extended data captured into wb_data.
  - Otherwise counter increments. Counter==TIMEOUT-1 without rvalid → EXC, cause 5.
  - flush → DRAIN. If rvalid arrives in the flush cycle → IDLE, data discarded.
- DRAIN: wait for mem_rvalid (discard), then IDLE. No timeout in DRAIN; no wb/exc/done output.
- RESP: one cycle.
  - Load: wb_valid=1, wb_rd, wb_data valid.
  - Store: wb_valid=0.
  - Both: done=1.
  - → IDLE.
- EXC: one cycle, exc_valid=1, exc_cause valid → IDLE. Store timeout is not possible (stores need no rvalid).
- mem_rvalid outside WAIT/DRAIN is ignored. Memory never returns rvalid in the same cycle as the ready handshake.
- Store lanes, with o=addr[1:0]:
  - SB: strb=4'b0001<<o, data={4{wdata[7:0]}}.
  - SH: strb=4'b0011<<o, data={2{wdata[15:0]}}.
  - SW: strb=4'hF, data=wdata.
- Load extract: s=mem_rdata>>(8*o).
  - LB: sign-extend s[7:0].
  - LH: sign-extend from s[15].
  - LW: mem_rdata.
  - LBU/LHU: zero-extend.
- Minimum latency, accept at cycle T, mem_ready immediate:
  - Store: done at T+2.
  - Load with rvalid at T+2: wb_valid at T+3.
- Async rst mid-op: immediate return to IDLE, mem_req drops. An outstanding response after reset is ignored.
- wb_data/wb_rd/exc_cause hold their last value when not pulsed.

Test Plan:
- LB addr 0x103, rdata 0x80FF_1234, ready immediate, rvalid next cycle → wb_valid at T+3, wb_data=0xFFFF_FF80, mem_addr=0x100, mem_wstrb=0.
- LHU addr 0x102, rdata 0x8001_0000 → wb_data=0x0000_8001. LH same → 0xFFFF_8001.
- SH addr 0x202, wdata 0x0000_BEEF, ready held 0 for 3 cycles → mem_req stable 3 cycles; then strb=4'b1100, wdata=0xBEEF_BEEF; done 1 cycle after ready; wb_valid stays 0.
- LW addr 0x101 → exc_valid 1 cycle, cause 4, mem_req never asserted. Load funct3=3 at the same address → cause 2.
- LW with rvalid never returned, TIMEOUT=4 → exc_valid cause 5 after 4 WAIT cycles; in_ready returns next cycle.
- Load flushed in WAIT, rvalid 2 cycles later → no wb_valid/done; in_ready low until the cycle after rvalid. Then a new LW to 0x300 completes normally.
